// File: rtl/serial_subtractor.sv
// Multi-cycle N-bit subtractor: computes a - b one SLICE per clock with a registered borrow,
// and produces ALU flags (borrow, signed overflow, zero, negative) alongside a done pulse.
module serial_subtractor #(
  parameter int unsigned N     = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_diff,
  output logic         o_borrow_out,
  output logic         o_overflow,
  output logic         o_zero,
  output logic         o_negative
);

  localparam int unsigned NumSlices = N / SLICE;
  localparam int unsigned IdxW      = (NumSlices > 1) ? $clog2(NumSlices) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumSlices - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e          r_state, w_state_d;
  logic [IdxW-1:0] r_idx, w_idx_d;
  logic            r_br, w_br_d;
  logic [N-1:0]    r_a, w_a_d;
  logic [N-1:0]    r_b, w_b_d;
  logic [N-1:0]    r_diff, w_diff_d;
  logic            r_busy, w_busy_d;
  logic            r_done, w_done_d;
  logic            r_borrow, w_borrow_d;
  logic            r_ovf, w_ovf_d;
  logic            r_zero, w_zero_d;
  logic            r_neg, w_neg_d;

  logic [SLICE-1:0] w_a_slice;
  logic [SLICE-1:0] w_b_slice;
  logic [SLICE:0]   w_t;
  logic [N-1:0]     w_diff_upd;
  logic             w_last;

  // Slice datapath: one SLICE-wide subtract with borrow-in, merged into the diff register.
  always_comb begin
    w_a_slice  = r_a[r_idx*SLICE +: SLICE];
    w_b_slice  = r_b[r_idx*SLICE +: SLICE];
    w_t        = {1'b0, w_a_slice} - {1'b0, w_b_slice} - {{SLICE{1'b0}}, r_br};
    w_diff_upd = r_diff;
    w_diff_upd[r_idx*SLICE +: SLICE] = w_t[SLICE-1:0];
    w_last     = (r_idx == LastIdx);
  end

  always_comb begin
    w_state_d  = r_state;
    w_idx_d    = r_idx;
    w_br_d     = r_br;
    w_a_d      = r_a;
    w_b_d      = r_b;
    w_diff_d   = r_diff;
    w_busy_d   = r_busy;
    w_done_d   = 1'b0;
    w_borrow_d = r_borrow;
    w_ovf_d    = r_ovf;
    w_zero_d   = r_zero;
    w_neg_d    = r_neg;

    case (r_state)
      StIdle, StDone: begin
        if (i_start) begin
          w_state_d  = StRun;
          w_a_d      = i_a;
          w_b_d      = i_b;
          w_br_d     = 1'b0;
          w_idx_d    = '0;
          w_diff_d   = '0;
          w_busy_d   = 1'b1;
          w_borrow_d = 1'b0;
          w_ovf_d    = 1'b0;
          w_zero_d   = 1'b0;
          w_neg_d    = 1'b0;
        end else begin
          w_state_d = StIdle;
          w_busy_d  = 1'b0;
        end
      end

      StRun: begin
        w_diff_d = w_diff_upd;
        w_br_d   = w_t[SLICE];
        w_idx_d  = w_last ? '0 : r_idx + 1'b1;
        if (w_last) begin
          w_state_d  = StDone;
          w_busy_d   = 1'b0;
          w_done_d   = 1'b1;
          w_borrow_d = w_t[SLICE];
          // Signed overflow only possible when operand signs differ.
          w_ovf_d    = (r_a[N-1] != r_b[N-1]) && (w_diff_upd[N-1] != r_a[N-1]);
          w_zero_d   = (w_diff_upd == '0);
          w_neg_d    = w_diff_upd[N-1];
        end
      end

      default: begin
        w_state_d = StIdle;
        w_busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_idx    <= '0;
      r_br     <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_idx    <= w_idx_d;
      r_br     <= w_br_d;
      r_a      <= w_a_d;
      r_b      <= w_b_d;
      r_diff   <= w_diff_d;
      r_busy   <= w_busy_d;
      r_done   <= w_done_d;
      r_borrow <= w_borrow_d;
      r_ovf    <= w_ovf_d;
      r_zero   <= w_zero_d;
      r_neg    <= w_neg_d;
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_diff       = r_diff;
  assign o_borrow_out = r_borrow;
  assign o_overflow   = r_ovf;
  assign o_zero       = r_zero;
  assign o_negative   = r_neg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: cycle-level arithmetic model plus directed vectors.
module tb_serial_subtractor;

  localparam int unsigned N     = 16;
  localparam int unsigned SLICE = 4;
  localparam int unsigned NSL   = N / SLICE;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         borrow_out;
  logic         overflow;
  logic         zero;
  logic         negative;

  int n_vec;
  int n_err;

  serial_subtractor #(
    .N    (N),
    .SLICE(SLICE)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_a         (a),
    .i_b         (b),
    .o_busy      (busy),
    .o_done      (done),
    .o_diff      (diff),
    .o_borrow_out(borrow_out),
    .o_overflow  (overflow),
    .o_zero      (zero),
    .o_negative  (negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a countdown of remaining slice cycles and plain integer arithmetic.
  bit           m_known = 0;
  bit           m_valid = 0;
  int           m_cnt = 0;
  bit           m_busy = 0;
  bit           m_done = 0;
  logic [N-1:0] m_a, m_b, m_diff;
  logic [3:0]   m_flags;

  always @(posedge clk) begin
    if (rst) begin
      m_known = 1; m_valid = 1; m_cnt = 0; m_busy = 0; m_done = 0;
      m_diff = '0; m_flags = '0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      m_busy = (m_cnt != 0);
      m_done = (m_cnt == 0);
      if (m_cnt == 0) begin
        int sa, sb, sd;
        sa = $signed(m_a);
        sb = $signed(m_b);
        sd = sa - sb;
        m_diff  = m_a - m_b;
        m_flags = {m_a < m_b, (sd > 32767) || (sd < -32768), m_diff == 0, m_diff[N-1]};
        m_valid = 1;
      end
    end else if (start) begin
      m_a = a; m_b = b; m_cnt = NSL; m_busy = 1; m_done = 0; m_valid = 0;
    end else begin
      m_busy = 0; m_done = 0;
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      if (m_valid) begin
        check("model_diff", 32'(diff), 32'(m_diff));
        check("model_flags", 32'({borrow_out, overflow, zero, negative}), 32'(m_flags));
      end
    end
  end

  task automatic start_op(input logic [N-1:0] va, input logic [N-1:0] vb);
    @(posedge clk); #1;
    start = 1'b1; a = va; b = vb;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts negedges until done; a missing done is reported as a failed comparison.
  task automatic wait_done(output int cycles);
    cycles = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        cycles = i;
        break;
      end
    end
    if (cycles == 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_result(input string name, input logic [N-1:0] ed, input logic [3:0] ef);
    check({name, "_diff"}, 32'(diff), 32'(ed));
    check({name, "_flags"}, 32'({borrow_out, overflow, zero, negative}), 32'(ef));
  endtask

  task automatic run_vec(input string name, input logic [N-1:0] va, input logic [N-1:0] vb,
                         input logic [N-1:0] ed, input logic [3:0] ef);
    int cyc;
    start_op(va, vb);
    wait_done(cyc);
    check({name, "_latency"}, 32'(cyc), 32'd5);
    expect_result(name, ed, ef);
  endtask

  initial begin
    int cyc;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; start = 1'b1; a = 16'd5; b = 16'd1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("reset_outputs", 32'({busy, done, diff, borrow_out, overflow, zero, negative}), 32'd0);

    // flags order: {borrow, overflow, zero, negative}
    run_vec("basic",     16'd5432, 16'd1234, 16'h1066, 4'b0000);
    run_vec("underflow", 16'd1234, 16'd5432, 16'hEF9A, 4'b1001);
    run_vec("sovf",      16'h8000, 16'h0001, 16'h7FFF, 4'b0100);
    run_vec("wrap",      16'h0000, 16'hFFFF, 16'h0001, 4'b1000);
    run_vec("zero",      16'h1234, 16'h1234, 16'h0000, 4'b0010);
    run_vec("ovf_brw",   16'h7FFF, 16'hFFFF, 16'h8000, 4'b1101);

    // start re-asserted during RUN is ignored
    start_op(16'd300, 16'd45);
    start = 1'b1; a = 16'd0; b = 16'd0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc);
    check("ignore_latency", 32'(cyc), 32'd4);
    expect_result("ignore", 16'd255, 4'b0000);

    // operand changes during RUN have no effect
    start_op(16'h0100, 16'h0001);
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      @(posedge clk); #1;
    end
    wait_done(cyc);
    expect_result("toggle", 16'h00FF, 4'b0000);

    // back-to-back accept in the DONE cycle
    run_vec("b2b_first", 16'd20, 16'd5, 16'd15, 4'b0000);
    start = 1'b1; a = 16'd10; b = 16'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc);
    check("b2b_latency", 32'(cyc), 32'd5);
    expect_result("b2b", 16'd7, 4'b0000);

    // reset on the second RUN cycle aborts the operation
    start_op(16'd9999, 16'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_outputs", 32'({busy, done, diff, borrow_out, overflow, zero, negative}), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
    end
    run_vec("after_rst", 16'd1000, 16'd1, 16'd999, 4'b0000);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
